// File: rtl/axis_uart_arbiter.sv
// rtl/axis_uart_arbiter.sv - round-robin packet arbiter of N_CH AXI-Stream requesters onto one UART TX stream
// Optional channel-tag beat ahead of each packet when CHAN_TAG_EN is defined.
module axis_uart_arbiter #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] s_tdata,
    input  logic [N_CH-1:0]        s_tvalid,
    input  logic [N_CH-1:0]        s_tlast,
    output logic [N_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [N_CH-1:0]        grant,
    output logic                   busy
);
    localparam int CW = $clog2(N_CH);
    localparam logic [CW-1:0] LAST_RST = CW'(N_CH - 1);

`ifdef CHAN_TAG_EN
    typedef enum logic [1:0] {S_IDLE, S_TAG, S_PASS} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PASS} state_t;
`endif

    state_t            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [CW-1:0]     gidx_q, gidx_d;
    logic [CW-1:0]     last_ch_q, last_ch_d;

    logic [CW-1:0]     win;
    logic              found;
    int                idx;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;

    // Round-robin scan starts just after the previous owner and wraps modulo N_CH.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last_ch_q) + k) % N_CH;
            if (!found && s_tvalid[CW'(idx)]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (gidx_q == CW'(i)) begin
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_ch_d = last_ch_q;
        s_tready  = '0;
        m_tdata   = '0;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    gidx_d       = win;
`ifdef CHAN_TAG_EN
                    state_d      = S_TAG;
`else
                    state_d      = S_PASS;
`endif
                end
            end
`ifdef CHAN_TAG_EN
            S_TAG: begin
                m_tvalid = 1'b1;
                m_tdata  = DATA_W'(8'hF0) | DATA_W'(gidx_q);
                if (m_tready) begin
                    state_d = S_PASS;
                end
            end
`endif
            S_PASS: begin
                m_tdata  = sel_data;
                m_tvalid = sel_valid;
                m_tlast  = sel_last;
                s_tready = grant_q & {N_CH{m_tready}};
                if (sel_valid && m_tready && sel_last) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    last_ch_d = gidx_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        // Handshake outputs stay quiet while reset is held, even before the first reset edge.
        if (rst) begin
            s_tready = '0;
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_ch_q <= LAST_RST;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_ch_q <= last_ch_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_uart_arbiter.sv
// tb/tb_axis_uart_arbiter.sv - self-checking bench for axis_uart_arbiter against a packet-level model
module tb_axis_uart_arbiter;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tlast;
    logic [N-1:0]   s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tready;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    axis_uart_arbiter #(.N_CH(N), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: owner channel (-1 when idle), previous owner, pending tag beat.
    int own = -1;
    int last = N - 1;
    bit tagp = 1'b0;
    bit known = 1'b0;

    // Packet sources and observation logs.
    int         rem[N];
    int         plen[N];
    int         pkts[N];
    logic [7:0] base[N];
    logic [N-1:0] drop;
    bit         use_src;
    int         order_q[$];
    logic [7:0] data_q[$];
    int         beats;

    function automatic int onehot_idx(input logic [N-1:0] g);
        int r = -1;
        for (int i = 0; i < N; i++) if (g == N'(1) << i) r = i;
        return r;
    endfunction

    function automatic int ord(input int i);
        return (i < order_q.size()) ? order_q[i] : -1;
    endfunction

    task automatic cycle();
        logic [7:0]   e_d;
        logic         e_v, e_l;
        logic [N-1:0] e_r;
        logic [N-1:0] rdy_obs;
        bit           got;
        if (use_src) begin
            for (int i = 0; i < N; i++) begin
                s_tvalid[i]       = (rem[i] > 0) && !drop[i];
                s_tlast[i]        = (rem[i] == 1);
                s_tdata[i*8 +: 8] = base[i] + 8'(plen[i] - rem[i]);
            end
        end
        #3;
        e_d = '0; e_v = 1'b0; e_l = 1'b0; e_r = '0;
        if (!rst && own >= 0) begin
            if (tagp) begin
                e_v = 1'b1;
                e_d = 8'hF0 | 8'(own);
            end else begin
                e_v      = s_tvalid[own];
                e_l      = s_tlast[own];
                e_d      = s_tdata[own*8 +: 8];
                e_r[own] = m_tready;
            end
        end
        check("m_tvalid", m_tvalid, e_v);
        check("m_tlast", m_tlast, e_l);
        check("s_tready", s_tready, e_r);
        if (e_v) check("m_tdata", m_tdata, e_d);
        if (known) begin
            check("grant", grant, (own < 0) ? 0 : (1 << own));
            check("busy", busy, own >= 0);
        end
        if (m_tvalid && m_tready) begin
            data_q.push_back(m_tdata);
            if (m_tlast) order_q.push_back(onehot_idx(grant));
        end
        beats += $countones(s_tready & s_tvalid);
        rdy_obs = s_tready;
        @(posedge clk);
        #1;
        if (rst) begin
            own = -1; last = N - 1; tagp = 1'b0; known = 1'b1;
        end else if (own < 0) begin
            got = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!got && s_tvalid[(last + k) % N]) begin
                    got = 1'b1;
                    own = (last + k) % N;
                end
            end
`ifdef CHAN_TAG_EN
            tagp = got;
`endif
        end else if (tagp) begin
            if (m_tready) tagp = 1'b0;
        end else if (s_tvalid[own] && m_tready && s_tlast[own]) begin
            last = own;
            own  = -1;
        end
        if (use_src) begin
            for (int i = 0; i < N; i++) begin
                if (rdy_obs[i] && s_tvalid[i]) begin
                    rem[i]--;
                    if (rem[i] == 0 && pkts[i] > 0) begin
                        pkts[i]--;
                        rem[i] = plen[i];
                    end
                end
            end
        end
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; pkts[i] = 0; plen[i] = 1; base[i] = 8'h00;
        end
        drop = '0; use_src = 1'b1; beats = 0;
        order_q.delete(); data_q.delete();
    endtask

    task automatic start(input int ch, input int len, input int n, input logic [7:0] b);
        plen[ch] = len; rem[ch] = len; pkts[ch] = n - 1; base[ch] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_tready = 1'b1;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0;
        clear();
        do_reset();

        // All three channels request 2-byte packets together.
        clear(); do_reset();
        start(0, 2, 1, 8'h10); start(1, 2, 1, 8'h20); start(2, 2, 1, 8'h30);
        m_tready = 1'b1;
        repeat (14) cycle();
        check("rr_count", order_q.size(), 3);
        check("rr_first", ord(0), 0);
        check("rr_second", ord(1), 1);
        check("rr_third", ord(2), 2);
        check("rr_beats", beats, 6);

        // Ch1 alone under a toggling m_tready.
        clear(); do_reset();
        start(1, 2, 1, 8'h41);
        for (int c = 0; c < 9; c++) begin
            m_tready = (c % 2 == 1);
            cycle();
        end
        check("stall_beats", beats, 2);
        check("stall_owner", ord(0), 1);

        // Ch0 drops tvalid mid-packet while ch2 waits.
        clear(); do_reset();
        m_tready = 1'b1;
        start(0, 3, 1, 8'h60); start(2, 2, 1, 8'h70);
        for (int c = 0; c < 16; c++) begin
            drop[0] = (c >= 2 && c <= 4);
            cycle();
        end
        check("hold_first", ord(0), 0);
        check("hold_second", ord(1), 2);

        // Reset in the middle of a ch1 packet, then ch0 and ch1 compete.
        clear(); do_reset();
        start(1, 3, 1, 8'h50);
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear();
        #2;
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tvalid", m_tvalid, 0);
        #1;
        start(0, 1, 1, 8'h80); start(1, 1, 1, 8'h90);
        repeat (10) cycle();
        check("post_rst_first", ord(0), 0);
        check("post_rst_second", ord(1), 1);
        check("post_rst_tlast_only_new", order_q.size(), 2);

        // Ch2 alone sends three 1-byte packets back to back.
        clear(); do_reset();
        start(2, 1, 3, 8'hA0);
        repeat (12) cycle();
        check("solo_count", order_q.size(), 3);
        for (int i = 0; i < 3; i++) check("solo_owner", ord(i), 2);
        check("solo_beats", beats, 3);

`ifdef CHAN_TAG_EN
        // Tag beat ahead of a ch2 packet.
        clear(); do_reset();
        start(2, 1, 1, 8'h55);
        repeat (5) cycle();
        check("tag_len", data_q.size(), 2);
        check("tag_byte", (data_q.size() > 0) ? data_q[0] : 8'h00, 8'hF2);
        check("tag_data", (data_q.size() > 1) ? data_q[1] : 8'h00, 8'h55);
`endif

        // Randomized traffic, including occasional resets.
        clear(); do_reset();
        use_src = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            s_tvalid = N'($urandom);
            s_tlast  = N'($urandom & $urandom);
            s_tdata  = (N*8)'($urandom);
            m_tready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
